// File: rtl/from_serial_pkg.sv
// Shared helpers and types for the handshaked multi-channel deserializer.
package from_serial_pkg;

  typedef enum logic {
    SLICE_LSB_FIRST = 1'b0,
    SLICE_MSB_FIRST = 1'b1
  } slice_order_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int no_cyc(input int bw_in, input int bw_out);
    return ceil_div(bw_out, bw_in);
  endfunction

  // At least one bit, so a single-state counter still has a legal width.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with occupancy level; storage is reset so the
// head reads zero after reset.
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full     = (cnt == LW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop & !empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push  = push & (!full | do_pop);
  assign pop_data = mem[rd_ptr];
  assign level    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/from_serial_hs.sv
// Multi-channel deserializer: assembles BW_IN-bit slices into BW_OUT-bit
// words per channel and queues them in a FWFT FIFO with valid/ready flow.
module from_serial_hs
  import from_serial_pkg::*;
#(
  parameter int NO_CH     = 10,
  parameter int BW_IN     = 2,
  parameter int BW_OUT    = 8,
  parameter int MSB_FIRST = 0,
  parameter int DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             vld_in,
  input  logic                             sof_in,
  output logic                             rdy_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]      data_in,
  output logic                             vld_out,
  input  logic                             rdy_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]     data_out,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic                             err_ovf,
  output logic                             err_align,
  input  logic                             clr_err
);

  localparam int NO_CYC = no_cyc(BW_IN, BW_OUT);
  localparam int W      = NO_CYC * BW_IN;
  localparam int CW     = ctr_width(NO_CYC);
  localparam int PW     = ctr_width(W);
  localparam slice_order_e ORDER = (MSB_FIRST != 0) ? SLICE_MSB_FIRST : SLICE_LSB_FIRST;
  localparam logic [CW-1:0] LAST = CW'(NO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [PW-1:0] slice_lo;
  logic          last, accept, push, pop;
  logic          fifo_full, fifo_empty;
  logic [NO_CH-1:0][BW_OUT-1:0] push_data;

  assign last    = (cnt_q == LAST);
  // Only a word-completing slice needs room; a same-cycle pop provides it.
  assign rdy_in  = !(last && fifo_full) || rdy_out;
  assign accept  = vld_in & rdy_in;
  // sof_in restarts the word: the slice lands at position 0 whatever cnt says.
  assign idx     = sof_in ? '0 : cnt_q;
  assign push    = accept && (idx == LAST);
  assign vld_out = !fifo_empty;
  assign pop     = vld_out & rdy_out;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = (idx == LAST) ? '0 : idx + 1'b1;
  end

  always_comb begin
    if (ORDER == SLICE_MSB_FIRST) slice_lo = PW'(W - (int'(idx) + 1) * BW_IN);
    else                          slice_lo = PW'(int'(idx) * BW_IN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < NO_CH; g++) begin : g_ch
    logic [W-1:0] asm_q, asm_d;

    always_comb begin
      asm_d = asm_q;
      asm_d[slice_lo +: BW_IN] = data_in[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      asm_q <= '0;
      else if (accept) asm_q <= asm_d;
    end

    // The pushed word already contains the slice being accepted this cycle.
    if (ORDER == SLICE_MSB_FIRST) begin : g_msb
      assign push_data[g] = asm_d[W-1 -: BW_OUT];
    end else begin : g_lsb
      assign push_data[g] = asm_d[BW_OUT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf   <= 1'b0;
      err_align <= 1'b0;
    end else if (clr_err) begin
      err_ovf   <= 1'b0;
      err_align <= 1'b0;
    end else begin
      if (vld_in && !rdy_in)                        err_ovf   <= 1'b1;
      if (accept && sof_in && (cnt_q != '0))        err_align <= 1'b1;
    end
  end

  word_fifo #(
    .WIDTH (NO_CH * BW_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (data_out),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_from_serial_hs.sv
// Directed table-driven bench for from_serial_hs across four slice/width configurations.
module tb_from_serial_hs;

  logic clk = 1'b0;
  logic rst_n, vld_in, sof_in, rdy_out, clr_err;
  logic [1:0][1:0] data_in;

  logic [3:0] rdy_in_v, vld_out_v, ovf_v, al_v;
  logic [1:0] lvl0, lvl1, lvl2, lvl3;
  logic [1:0][7:0] d_u0, d_u1;
  logic [1:0][6:0] d_u2, d_u3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(8), .MSB_FIRST(0), .DEPTH(2)) u0 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .sof_in(sof_in), .rdy_in(rdy_in_v[0]),
    .data_in(data_in), .vld_out(vld_out_v[0]), .rdy_out(rdy_out), .data_out(d_u0),
    .level(lvl0), .err_ovf(ovf_v[0]), .err_align(al_v[0]), .clr_err(clr_err));
  from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(8), .MSB_FIRST(1), .DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .sof_in(sof_in), .rdy_in(rdy_in_v[1]),
    .data_in(data_in), .vld_out(vld_out_v[1]), .rdy_out(rdy_out), .data_out(d_u1),
    .level(lvl1), .err_ovf(ovf_v[1]), .err_align(al_v[1]), .clr_err(clr_err));
  from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(7), .MSB_FIRST(0), .DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .sof_in(sof_in), .rdy_in(rdy_in_v[2]),
    .data_in(data_in), .vld_out(vld_out_v[2]), .rdy_out(rdy_out), .data_out(d_u2),
    .level(lvl2), .err_ovf(ovf_v[2]), .err_align(al_v[2]), .clr_err(clr_err));
  from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(7), .MSB_FIRST(1), .DEPTH(2)) u3 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .sof_in(sof_in), .rdy_in(rdy_in_v[3]),
    .data_in(data_in), .vld_out(vld_out_v[3]), .rdy_out(rdy_out), .data_out(d_u3),
    .level(lvl3), .err_ovf(ovf_v[3]), .err_align(al_v[3]), .clr_err(clr_err));

  typedef struct {
    logic       vld, sof, rdo, clr;
    logic [1:0] d0, d1;
    logic       e_rdy, e_vld;
    logic [1:0] e_lvl;
    logic       e_ovf, e_al, chk_d;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t vt [34];

  function automatic vec_t mk(logic vld, sof, rdo, clr, logic [1:0] d0, d1,
                              logic e_rdy, e_vld, logic [1:0] e_lvl,
                              logic e_ovf, e_al, chk_d, logic [7:0] e0, e1);
    vec_t v;
    v.vld = vld; v.sof = sof; v.rdo = rdo; v.clr = clr; v.d0 = d0; v.d1 = d1;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
    v.e_al = e_al; v.chk_d = chk_d; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vld_in  = vt[i].vld;
      sof_in  = vt[i].sof;
      rdy_out = vt[i].rdo;
      clr_err = vt[i].clr;
      data_in = {vt[i].d1, vt[i].d0};
      #3;
      chk($sformatf("v%0d rdy_in", i + 1), 32'(rdy_in_v[0]), 32'(vt[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d vld_out", i + 1), 32'(vld_out_v[0]), 32'(vt[i].e_vld));
      chk($sformatf("v%0d level", i + 1), 32'(lvl0), 32'(vt[i].e_lvl));
      chk($sformatf("v%0d err_ovf", i + 1), 32'(ovf_v[0]), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d err_align", i + 1), 32'(al_v[0]), 32'(vt[i].e_al));
      if (vt[i].chk_d) begin
        chk($sformatf("v%0d data0", i + 1), 32'(d_u0[0]), 32'(vt[i].e0));
        chk($sformatf("v%0d data1", i + 1), 32'(d_u0[1]), 32'(vt[i].e1));
      end
    end
  endtask

  initial begin
    //            vld sof rdo clr d0 d1  rdy vld lvl ovf al chk e0     e1
    vt[0]  = mk(1, 0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    vt[1]  = mk(1, 0, 0, 0, 2, 3,  1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    vt[2]  = mk(1, 0, 0, 0, 3, 3,  1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    vt[3]  = mk(1, 0, 0, 0, 0, 3,  1, 1, 1, 0, 0, 1, 8'h39, 8'hFF);
    vt[4]  = mk(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[5]  = mk(1, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[6]  = mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[7]  = mk(1, 0, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[8]  = mk(1, 0, 0, 0, 0, 3,  1, 1, 1, 0, 0, 1, 8'h01, 8'hE4);
    vt[9]  = mk(1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 1, 8'h01, 8'hE4);
    vt[10] = mk(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 1, 8'h01, 8'hE4);
    vt[11] = mk(1, 0, 0, 0, 2, 1,  1, 1, 1, 0, 0, 1, 8'h01, 8'hE4);
    vt[12] = mk(1, 0, 0, 0, 3, 1,  1, 1, 2, 0, 0, 1, 8'h01, 8'hE4);
    vt[13] = mk(1, 0, 0, 0, 3, 2,  1, 1, 2, 0, 0, 1, 8'h01, 8'hE4);
    vt[14] = mk(1, 0, 0, 0, 2, 2,  1, 1, 2, 0, 0, 1, 8'h01, 8'hE4);
    vt[15] = mk(1, 0, 0, 0, 1, 2,  1, 1, 2, 0, 0, 1, 8'h01, 8'hE4);
    vt[16] = mk(1, 0, 0, 0, 0, 2,  0, 1, 2, 1, 0, 1, 8'h01, 8'hE4);
    vt[17] = mk(1, 0, 1, 0, 0, 2,  1, 1, 2, 1, 0, 1, 8'hE4, 8'h55);
    vt[18] = mk(0, 0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 1, 8'h1B, 8'hAA);
    vt[19] = mk(0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    vt[20] = mk(1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    vt[21] = mk(1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    vt[22] = mk(1, 1, 0, 0, 2, 1,  1, 0, 0, 1, 1, 0, 8'h00, 8'h00);
    vt[23] = mk(1, 0, 0, 0, 1, 1,  1, 0, 0, 1, 1, 0, 8'h00, 8'h00);
    vt[24] = mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 8'h00, 8'h00);
    vt[25] = mk(1, 0, 0, 0, 3, 1,  1, 1, 1, 1, 1, 1, 8'hC6, 8'h55);
    vt[26] = mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[27] = mk(1, 0, 0, 0, 2, 2,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[28] = mk(1, 1, 0, 1, 3, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[29] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[30] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vt[31] = mk(1, 0, 0, 0, 1, 2,  1, 1, 1, 0, 0, 1, 8'h43, 8'h80);
    vt[32] = mk(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 1, 8'h43, 8'h80);
    vt[33] = mk(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 1, 8'h43, 8'h80);

    rst_n = 1'b0; vld_in = 1'b0; sof_in = 1'b0; rdy_out = 1'b0; clr_err = 1'b0;
    data_in = '0;
    #3;
    chk("reset vld_out", 32'(vld_out_v[0]), 32'h0);
    chk("reset level", 32'(lvl0), 32'h0);
    chk("reset rdy_in", 32'(rdy_in_v[0]), 32'h1);
    chk("reset data", 32'(d_u0), 32'h0);
    chk("reset errors", 32'({ovf_v[0], al_v[0]}), 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_vecs(0, 3);
    chk("msb8 word A", 32'(d_u1), 32'hFF6C);
    chk("lsb7 word A ch0", 32'(d_u2[0]), 32'h39);
    chk("lsb7 word A ch1", 32'(d_u2[1]), 32'h7F);
    chk("msb7 word A ch0", 32'(d_u3[0]), 32'h36);
    chk("msb7 word A ch1", 32'(d_u3[1]), 32'h7F);

    run_vecs(4, 8);
    chk("msb8 word B", 32'(d_u1), 32'h1B40);
    chk("lsb7 word B ch0", 32'(d_u2[0]), 32'h01);
    chk("lsb7 word B ch1", 32'(d_u2[1]), 32'h64);
    chk("msb7 word B ch0", 32'(d_u3[0]), 32'h20);
    chk("msb7 word B ch1", 32'(d_u3[1]), 32'h0D);

    run_vecs(9, 33);

    // Asynchronous reset mid-word with one word queued.
    #2 rst_n = 1'b0; vld_in = 1'b0; sof_in = 1'b0;
    #1;
    chk("async rst vld_out", 32'(vld_out_v[0]), 32'h0);
    chk("async rst level", 32'(lvl0), 32'h0);
    chk("async rst rdy_in", 32'(rdy_in_v[0]), 32'h1);
    chk("async rst data", 32'(d_u0), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vld_in  = 1'b1;
      data_in = {2'(k + 1), 2'd2};
      @(posedge clk); #1;
      if (k < 3) chk($sformatf("post rst slice%0d vld_out", k), 32'(vld_out_v[0]), 32'h0);
    end
    vld_in = 1'b0;
    chk("post rst vld_out", 32'(vld_out_v[0]), 32'h1);
    chk("post rst level", 32'(lvl0), 32'h1);
    chk("post rst lsb8 word", 32'(d_u0), 32'h39AA);
    chk("post rst msb8 word", 32'(d_u1), 32'h6CAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/from_serial_hs.md
# from_serial_hs

Multi-channel deserializer with handshakes. It gathers NO_CH parallel streams of BW_IN-bit slices into BW_OUT-bit words per channel, and buffers the completed words in a small output FIFO with valid/ready flow control. It sits between the narrow-lane front-end links and the wide per-channel datapath, as the flow-controlled successor of the plain counting deserializer. New over that block:
- BW_OUT need not be a multiple of BW_IN.
- Selectable slice order.
- Start-of-word realignment.
- Backpressure.
- Sticky error reporting.

## Interface
Parameters:
- NO_CH, 10: number of independent channels, all sharing one slice counter.
- BW_IN, 2: slice width per channel; must satisfy 1 ≤ BW_IN ≤ BW_OUT.
- BW_OUT, 8: assembled word width per channel.
- MSB_FIRST, 0: 0 = first slice lands in the LSBs; 1 = first slice lands in the MSBs.
- DEPTH, 2: output FIFO depth in words; a power of 2, ≥ 2.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- vld_in, input, 1: a slice is present on data_in.
- sof_in, input, 1: the current slice is slice 0 of a new word; qualified by vld_in.
- rdy_in, output, 1: the block can accept a slice this cycle.
- data_in, input, [NO_CH-1:0][BW_IN-1:0]: one slice per channel.
- vld_out, output, 1: the FIFO head is valid.
- rdy_out, input, 1: downstream accepts the head this cycle.
- data_out, output, [NO_CH-1:0][BW_OUT-1:0]: FIFO head word.
- level, output, $clog2(DEPTH+1): FIFO occupancy.
- err_ovf, output, 1: sticky flag; a slice was presented while rdy_in = 0.
- err_align, output, 1: sticky flag; sof_in arrived mid-word.
- clr_err, input, 1: synchronous clear of both error flags.

## Operation
Word format:
- NO_CYC = ceil(BW_OUT/BW_IN) slices per word; W = NO_CYC·BW_IN.
- Slice k (k = 0 is first) builds a padded W-bit word.
- MSB_FIRST = 0: slice k goes to padded[k·BW_IN +: BW_IN]; data_out = padded[BW_OUT-1:0], so excess top bits of the last slice are discarded.
- MSB_FIRST = 1: slice k goes to padded[W-1-k·BW_IN -: BW_IN]; data_out = padded[W-1 -: BW_OUT], so excess low bits of the last slice are discarded.

Slice acceptance:
- A slice is accepted when vld_in & rdy_in.
- The slice counter cnt runs 0..NO_CYC-1 and wraps to 0 after the last slice.
- All channels share cnt.

Word completion:
- When cnt = NO_CYC-1 on an accepted slice, the complete word (including that slice) is pushed into the FIFO and cnt returns to 0.
- Partial-word storage needs no clearing; every bit is overwritten before the next push.

Realignment:
- An accepted slice with sof_in = 1 is written as slice 0 and sets cnt to 1, or pushes immediately if NO_CYC = 1.
- If cnt ≠ 0 at that moment, the partial word is discarded and err_align is set.
- sof_in with vld_in = 0 is ignored.

Flow control:
- rdy_in = !(cnt = NO_CYC-1 && full) || rdy_out.
- A mid-word slice is always accepted.
- A last slice needs FIFO room; a same-cycle pop provides that room. The rdy_out→rdy_in path is combinational.

Overflow:
- vld_in = 1 with rdy_in = 0: the slice is dropped, cnt is unchanged, and err_ovf is set.

Error flags:
- Both flags are sticky until clr_err.
- clr_err has priority over a same-cycle set.

FIFO:
- First-word-fall-through.
- Pop on vld_out & rdy_out.
- Simultaneous push and pop leaves level unchanged and is legal when full.

## Timing
- Latency: a word whose last slice is accepted at edge N is on data_out with vld_out = 1 after edge N, provided the FIFO was empty.
- Throughput: one slice per cycle sustained, i.e. one word per NO_CYC cycles; no bubbles at wrap.
- Output handshake: data_out and vld_out hold stable while vld_out & !rdy_out.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - cnt = 0, level = 0, vld_out = 0.
  - data_out = 0 (FIFO storage reset).
  - err_ovf = 0, err_align = 0.
  - rdy_in = 1.
  - A partial word is lost.
- Deassertion is synchronised externally; the first accepted slice after reset is slice 0, with or without sof_in.

## Structure
- Package from_serial_pkg:
  - ceil_div function.
  - NO_CYC / counter-width helper.
  - Slice-order enum (LSB_FIRST, MSB_FIRST).
- Sub-module word_fifo:
  - Parameters: width NO_CH·BW_OUT, DEPTH.
  - Provides FWFT, level, full, empty.
  - Asynchronous active-low reset.
- The top level holds:
  - The slice counter.
  - The per-channel assembly registers, in a generate loop.
  - The rdy/error logic.

## Test plan
- **LSB-first assembly.** NO_CH = 2, BW_IN = 2, BW_OUT = 8, MSB_FIRST = 0; ch0 slices 1, 2, 3, 0; ch1 slices 3, 3, 3, 3 → data_out[0] = 8'h39, data_out[1] = 8'hFF, vld_out one cycle after the 4th accept.
- **MSB-first assembly.** Same stimulus with MSB_FIRST = 1 → data_out[0] = 8'h6C.
- **Non-multiple width.** BW_OUT = 7, BW_IN = 2, LSB-first; slices 3, 3, 3, 3 → 7'h7F (NO_CYC = 4). With MSB-first, slices 1, 0, 0, 0 → 7'h20.
- **Backpressure.** DEPTH = 2, rdy_out = 0; stream 11 slices → level = 2, rdy_in = 0 with cnt = 3. Pulse rdy_out for 1 cycle → rdy_in = 1 that cycle; the third word is pushed; level stays 2.
- **Errors.** Hold vld_in while rdy_in = 0 → err_ovf = 1 and the slice is dropped. sof_in after 2 slices → err_align = 1, and the next 4 slices form a correct word. clr_err → both flags 0 the next cycle.
- **Reset mid-operation.** Assert rst_n low with cnt = 2 and level = 1 → vld_out, level and cnt are 0 immediately. After release, 4 slices produce one correct word.
